// File: rtl/tip_memory_unit.sv
`default_nettype none
// ============================================================================
// Module  : tip_memory_unit
// Brief   : Word RAM, TIP status registers, indirect channels and a
//           ready-handshaked peripheral window with timeout.
// Revision: 1.0
// ============================================================================
module tip_memory_unit #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 11,
  parameter int MEM_DEPTH    = 512,
  parameter int N_IND        = 2,
  parameter int PERI_BASE    = 'h300,
  parameter int PERI_SIZE    = 'h100,
  parameter int PERI_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset_bar,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              we_i,
  input  logic              re_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic              busy_o,
  input  logic [DATA_W-1:0] wreg_i,
  input  logic              carry_in_i,
  input  logic              zero_in_i,
  output logic              carry_out_o,
  output logic              zero_out_o,
  output logic [7:0]        peri_addr_o,
  output logic [DATA_W-1:0] peri_wdata_o,
  output logic              peri_we_o,
  output logic              peri_re_o,
  input  logic [DATA_W-1:0] peri_rdata_i,
  input  logic              peri_ready_i,
  input  logic              peri_irq_i,
  output logic              irq_o
);

  localparam int                PW        = $clog2(MEM_DEPTH);
  localparam int                CW        = $clog2(PERI_TIMEOUT + 1);
  localparam logic [DATA_W-1:0] DEAD_WORD = DATA_W'(16'hDEAD);
  localparam logic [31:0]       A_WREG    = 32'h200;
  localparam logic [31:0]       A_CARRY   = 32'h201;
  localparam logic [31:0]       A_ZERO    = 32'h202;
  localparam logic [31:0]       A_CTRL    = 32'h203;
  localparam logic [31:0]       A_IND     = 32'h210;
  localparam logic [CW-1:0]     CNT_LAST  = CW'(PERI_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WR_WAIT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              peri_re_q, peri_re_d;
  logic              peri_we_q, peri_we_d;
  logic [7:0]        peri_addr_q, peri_addr_d;
  logic [DATA_W-1:0] peri_wdata_q, peri_wdata_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              carry_q, zero_q, irq_en_q, to_err_q;
  logic [PW-1:0]     ptr_q [N_IND];
  logic [N_IND-1:0]  autoinc_q;
  logic [DATA_W-1:0] mem [MEM_DEPTH];

  logic              w_req, w_wr, w_rd;
  logic [31:0]       w_a, w_ind_off;
  logic              w_hit_ram, w_hit_tip, w_hit_ind, w_hit_peri, w_ram_acc;
  logic              w_to_abort;
  logic [N_IND-1:0]  w_ind_sel;
  logic [PW-1:0]     w_ind_ptr, w_ram_idx;
  logic [DATA_W-1:0] w_ind_word, w_local_rdata;

  // Address decode; local regions take priority over the peripheral window.
  always_comb begin
    w_req      = (we_i | re_i) & ~busy_q;
    w_wr       = w_req & we_i;
    w_rd       = w_req & re_i & ~we_i;
    w_a        = 32'(addr_i);
    w_ind_off  = w_a - A_IND;
    w_hit_ram  = w_a < 32'(MEM_DEPTH);
    w_hit_tip  = (w_a >= A_WREG) && (w_a <= A_CTRL);
    w_hit_ind  = (w_a >= A_IND) && (w_a < A_IND + 32'(2 * N_IND));
    w_hit_peri = !w_hit_ram && !w_hit_tip && !w_hit_ind &&
                 (w_a >= 32'(PERI_BASE)) && (w_a < 32'(PERI_BASE + PERI_SIZE));
    w_ind_sel  = '0;
    w_ind_ptr  = '0;
    w_ind_word = '0;
    for (int k = 0; k < N_IND; k++) begin
      if (w_hit_ind && (w_ind_off[31:1] == 31'(k))) begin
        w_ind_sel[k]          = 1'b1;
        w_ind_ptr             = ptr_q[k];
        w_ind_word[PW-1:0]    = ptr_q[k];
        w_ind_word[DATA_W-1]  = autoinc_q[k];
      end
    end
    w_ram_acc = w_hit_ram | (w_hit_ind & ~w_ind_off[0]);
    w_ram_idx = w_hit_ram ? addr_i[PW-1:0] : w_ind_ptr;
  end

  always_comb begin
    w_local_rdata = DEAD_WORD;
    if (w_ram_acc)            w_local_rdata = mem[w_ram_idx];
    else if (w_hit_ind)       w_local_rdata = w_ind_word;
    else if (w_a == A_WREG)   w_local_rdata = wreg_i;
    else if (w_a == A_CARRY)  w_local_rdata = DATA_W'(carry_q);
    else if (w_a == A_ZERO)   w_local_rdata = DATA_W'(zero_q);
    else if (w_a == A_CTRL)   w_local_rdata = DATA_W'({to_err_q, irq_en_q, peri_irq_i});
  end

  always_ff @(posedge clk) begin
    if (w_wr && w_ram_acc) mem[w_ram_idx] <= wr_data_i;
  end

  // Software writes to the status bits win over the ALU inputs for one edge.
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      irq_en_q  <= 1'b0;
      to_err_q  <= 1'b0;
      autoinc_q <= '0;
      for (int k = 0; k < N_IND; k++) ptr_q[k] <= '0;
    end else begin
      carry_q <= (w_wr && w_a == A_CARRY) ? wr_data_i[0] : carry_in_i;
      zero_q  <= (w_wr && w_a == A_ZERO)  ? wr_data_i[0] : zero_in_i;
      if (w_wr && w_a == A_CTRL) irq_en_q <= wr_data_i[1];
      if (w_to_abort)                                to_err_q <= 1'b1;
      else if (w_wr && w_a == A_CTRL && wr_data_i[2]) to_err_q <= 1'b0;
      for (int k = 0; k < N_IND; k++) begin
        if (w_ind_sel[k]) begin
          if (w_ind_off[0]) begin
            if (w_wr) begin
              ptr_q[k]     <= wr_data_i[PW-1:0];
              autoinc_q[k] <= wr_data_i[DATA_W-1];
            end
          end else if ((w_wr || w_rd) && autoinc_q[k]) begin
            ptr_q[k] <= ptr_q[k] + PW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      peri_re_q    <= 1'b0;
      peri_we_q    <= 1'b0;
      peri_addr_q  <= '0;
      peri_wdata_q <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      peri_re_q    <= peri_re_d;
      peri_we_q    <= peri_we_d;
      peri_addr_q  <= peri_addr_d;
      peri_wdata_q <= peri_wdata_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    busy_d       = busy_q;
    peri_re_d    = peri_re_q;
    peri_we_d    = peri_we_q;
    peri_addr_d  = peri_addr_q;
    peri_wdata_d = peri_wdata_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = 1'b0;
    w_to_abort   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_req && w_hit_peri) begin
          state_d      = we_i ? ST_WR_WAIT : ST_RD_WAIT;
          cnt_d        = '0;
          busy_d       = 1'b1;
          peri_we_d    = we_i;
          peri_re_d    = ~we_i;
          peri_addr_d  = 8'(w_a - 32'(PERI_BASE));
          peri_wdata_d = wr_data_i;
        end else if (w_rd) begin
          rd_valid_d = 1'b1;
          rd_data_d  = w_local_rdata;
        end
      end
      ST_RD_WAIT, ST_WR_WAIT: begin
        // Ready on the final wait cycle still completes the transfer.
        if (peri_ready_i || cnt_q == CNT_LAST) begin
          state_d    = ST_IDLE;
          busy_d     = 1'b0;
          peri_re_d  = 1'b0;
          peri_we_d  = 1'b0;
          w_to_abort = ~peri_ready_i;
          if (state_q == ST_RD_WAIT) begin
            rd_valid_d = 1'b1;
            rd_data_d  = peri_ready_i ? peri_rdata_i : DEAD_WORD;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d   = ST_IDLE;
        busy_d    = 1'b0;
        peri_re_d = 1'b0;
        peri_we_d = 1'b0;
      end
    endcase
  end

  assign rd_data_o    = rd_data_q;
  assign rd_valid_o   = rd_valid_q;
  assign busy_o       = busy_q;
  assign carry_out_o  = carry_q;
  assign zero_out_o   = zero_q;
  assign peri_addr_o  = peri_addr_q;
  assign peri_wdata_o = peri_wdata_q;
  assign peri_we_o    = peri_we_q;
  assign peri_re_o    = peri_re_q;
  assign irq_o        = peri_irq_i & irq_en_q;

endmodule
`default_nettype wire

// File: tb/tb_tip_memory_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_tip_memory_unit
// Brief   : Scoreboard bench for tip_memory_unit with a behavioural model.
// Revision: 1.0
// ============================================================================
module tb_tip_memory_unit;
  localparam int DEPTH = 512;
  localparam int NI    = 2;
  localparam int PBASE = 'h300;
  localparam int PSIZE = 'h100;
  localparam int TMO   = 15;
  localparam logic [15:0] DEAD = 16'hDEAD;

  logic        clk = 1'b0;
  logic        reset_bar;
  logic [10:0] addr_i;
  logic [15:0] wr_data_i, rd_data_o, wreg_i, peri_wdata_o, peri_rdata_i;
  logic        we_i, re_i, rd_valid_o, busy_o, carry_in_i, zero_in_i;
  logic        carry_out_o, zero_out_o, peri_we_o, peri_re_o, peri_ready_i;
  logic        peri_irq_i, irq_o;
  logic [7:0]  peri_addr_o;

  always #5 clk = ~clk;

  tip_memory_unit dut (
    .clk(clk), .reset_bar(reset_bar), .addr_i(addr_i), .wr_data_i(wr_data_i),
    .we_i(we_i), .re_i(re_i), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
    .busy_o(busy_o), .wreg_i(wreg_i), .carry_in_i(carry_in_i), .zero_in_i(zero_in_i),
    .carry_out_o(carry_out_o), .zero_out_o(zero_out_o), .peri_addr_o(peri_addr_o),
    .peri_wdata_o(peri_wdata_o), .peri_we_o(peri_we_o), .peri_re_o(peri_re_o),
    .peri_rdata_i(peri_rdata_i), .peri_ready_i(peri_ready_i), .peri_irq_i(peri_irq_i),
    .irq_o(irq_o)
  );

  typedef struct { logic [15:0] data; int cyc; bit dc; } exp_t;
  exp_t sbq[$];

  int checks = 0, errors = 0, cyc = 0, peri_lat = 1, pcnt = 0;
  bit rnd_status = 0;
  logic [15:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  int          m_ptr [NI];
  bit          m_ai [NI];
  bit          m_irq_en = 0, m_to_err = 0, m_carry = 0, m_zero = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every read completion is matched against the oldest expectation.
  always @(negedge clk) begin
    if (reset_bar === 1'b1) begin
      if (rd_valid_o === 1'b1) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rd_valid: got data %h at cycle %0d, none expected", rd_data_o, cyc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          if ((!e.dc && rd_data_o !== e.data) || cyc != e.cyc || (e.dc && $isunknown(rd_valid_o))) begin
            errors++;
            $display("FAIL read_data: got %h at cycle %0d expected %h at cycle %0d", rd_data_o, cyc, e.data, e.cyc);
          end
        end
      end else if (rd_valid_o !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL rd_valid_unknown: got %b expected 0 or 1", rd_valid_o);
      end
    end
  end

  // Peripheral responder: raises ready on the peri_lat-th cycle of a strobe.
  always @(negedge clk) begin
    if (peri_re_o === 1'b1 || peri_we_o === 1'b1) begin
      pcnt++;
      peri_ready_i = (pcnt == peri_lat);
    end else begin
      pcnt = 0;
      peri_ready_i = 1'b0;
    end
  end

  function automatic bit is_ind(input int a);
    return (a >= 'h210) && (a < 'h210 + 2 * NI);
  endfunction

  task automatic m_write(input int a, input logic [15:0] d);
    int k;
    if (a < DEPTH) begin
      m_mem[a] = d; m_known[a] = 1;
    end else if (a == 'h203) begin
      m_irq_en = d[1];
      if (d[2]) m_to_err = 0;
    end else if (is_ind(a)) begin
      k = (a - 'h210) / 2;
      if (a % 2 == 1) begin
        m_ptr[k] = d % DEPTH; m_ai[k] = d[15];
      end else begin
        m_mem[m_ptr[k]] = d; m_known[m_ptr[k]] = 1;
        if (m_ai[k]) m_ptr[k] = (m_ptr[k] + 1) % DEPTH;
      end
    end
  endtask

  task automatic m_read(input int a, output logic [15:0] v, output bit dc);
    int k;
    dc = 0; v = DEAD;
    if (a < DEPTH) begin
      v = m_mem[a]; dc = !m_known[a];
    end else if (a == 'h200) v = wreg_i;
    else if (a == 'h201) v = {15'b0, m_carry};
    else if (a == 'h202) v = {15'b0, m_zero};
    else if (a == 'h203) v = {13'b0, m_to_err, m_irq_en, peri_irq_i};
    else if (is_ind(a)) begin
      k = (a - 'h210) / 2;
      if (a % 2 == 1) v = (16'(m_ai[k]) << 15) | 16'(m_ptr[k]);
      else begin
        v = m_mem[m_ptr[k]]; dc = !m_known[m_ptr[k]];
        if (m_ai[k]) m_ptr[k] = (m_ptr[k] + 1) % DEPTH;
      end
    end
  endtask

  task automatic txn(input bit w, input bit r, input int a, input logic [15:0] d,
                     input int lat, input logic [15:0] prd, input bit poke);
    bit peri; logic [15:0] v; bit dc; int eff, n, bad; exp_t e;
    @(negedge clk);
    m_carry = carry_in_i; m_zero = zero_in_i;
    if (rnd_status) begin carry_in_i = 1'($urandom); zero_in_i = 1'($urandom); end
    peri = (a >= PBASE) && (a < PBASE + PSIZE);
    eff = (lat <= TMO) ? lat : TMO;
    peri_lat = lat; peri_rdata_i = prd;
    addr_i = 11'(a); wr_data_i = d; we_i = w; re_i = r;
    if (w) begin
      if (!peri) m_write(a, d);
    end else if (r) begin
      if (peri) begin
        e.data = (lat <= TMO) ? prd : DEAD; e.cyc = cyc + 1 + eff; e.dc = 0;
      end else begin
        m_read(a, v, dc);
        e.data = v; e.cyc = cyc + 1; e.dc = dc;
      end
      sbq.push_back(e);
    end
    @(posedge clk); @(negedge clk);
    we_i = 0; re_i = 0;
    if (peri && (w || r)) begin
      chk("peri_addr", 32'(peri_addr_o), 32'(a - PBASE));
      chk("peri_strobes", {30'b0, peri_we_o, peri_re_o}, {30'b0, w, !w});
      if (w) chk("peri_wdata", 32'(peri_wdata_o), 32'(d));
      n = 0; bad = 0;
      while (busy_o === 1'b1 && n < 40) begin
        if ({peri_we_o, peri_re_o} !== {w, !w}) bad++;
        if (poke && n == 0) begin
          we_i = 1; addr_i = 11'd7; wr_data_i = 16'h5A5A;
        end else we_i = 0;
        n++;
        @(negedge clk);
      end
      we_i = 0;
      chk("busy_cycles", 32'(n), 32'(eff));
      chk("strobe_held", 32'(bad), 32'd0);
      chk("strobes_dropped", {30'b0, peri_we_o, peri_re_o}, 32'd0);
      if (lat > TMO) m_to_err = 1;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin m_ptr[k] = 0; m_ai[k] = 0; end
    m_irq_en = 0; m_to_err = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int unm [6];
    unm = '{'h204, 'h20F, 'h214, 'h2FF, 'h400, 'h7FF};
    reset_bar = 0; addr_i = 0; wr_data_i = 0; we_i = 0; re_i = 0; wreg_i = 16'hC0DE;
    carry_in_i = 1; zero_in_i = 1; peri_rdata_i = 0; peri_ready_i = 0; peri_irq_i = 1;
    for (int i = 0; i < DEPTH; i++) m_known[i] = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_rd_data", 32'(rd_data_o), 0);
    chk("reset_flags", {24'b0, rd_valid_o, busy_o, carry_out_o, zero_out_o,
                        peri_we_o, peri_re_o, irq_o, 1'b0}, 0);
    chk("reset_peri_bus", {8'b0, peri_addr_o, peri_wdata_o}, 0);
    carry_in_i = 0; zero_in_i = 0;
    reset_bar = 1;

    txn(0, 1, 'h211, 0, 0, 0, 0);
    txn(0, 1, 'h203, 0, 0, 0, 0);
    txn(1, 0, 5, 16'h1234, 0, 0, 0);
    txn(0, 1, 5, 0, 0, 0, 0);
    txn(0, 1, 'h1FF, 0, 0, 0, 0);
    txn(0, 1, 'h200, 0, 0, 0, 0);
    txn(1, 0, 'h211, 16'h81FE, 0, 0, 0);
    txn(1, 0, 'h210, 16'h000A, 0, 0, 0);
    txn(1, 0, 'h210, 16'h000B, 0, 0, 0);
    txn(1, 0, 'h210, 16'h000C, 0, 0, 0);
    txn(0, 1, 'h211, 0, 0, 0, 0);
    txn(0, 1, 'h1FE, 0, 0, 0, 0);
    txn(0, 1, 'h1FF, 0, 0, 0, 0);
    txn(0, 1, 0, 0, 0, 0, 0);

    carry_in_i = 0; zero_in_i = 1;
    txn(1, 0, 'h201, 16'h0003, 0, 0, 0);
    chk("carry_sw_wins", 32'(carry_out_o), 1);
    @(negedge clk);
    chk("carry_follows_alu", 32'(carry_out_o), 0);
    txn(1, 0, 'h202, 16'h0000, 0, 0, 0);
    chk("zero_sw_wins", 32'(zero_out_o), 0);
    @(negedge clk);
    chk("zero_follows_alu", 32'(zero_out_o), 1);
    txn(0, 1, 'h202, 0, 0, 0, 0);

    txn(1, 0, 'h203, 16'h0002, 0, 0, 0);
    chk("irq_enabled", 32'(irq_o), 1);
    peri_irq_i = 0; #1;
    chk("irq_low", 32'(irq_o), 0);

    txn(1, 0, 7, 16'h1111, 0, 0, 0);
    txn(0, 1, 'h305, 0, 3, 16'hBEEF, 1);
    txn(0, 1, 7, 0, 0, 0, 0);
    txn(1, 0, 'h3A0, 16'h7777, 99, 0, 0);
    txn(0, 1, 'h203, 0, 0, 0, 0);
    txn(1, 0, 'h203, 16'h0004, 0, 0, 0);
    txn(0, 1, 'h203, 0, 0, 0, 0);

    // Reset while a peripheral read is waiting.
    @(negedge clk);
    addr_i = 11'h320; re_i = 1; peri_lat = 99;
    @(posedge clk); @(negedge clk);
    re_i = 0;
    chk("busy_in_rd_wait", 32'(busy_o), 1);
    @(negedge clk);
    #2 reset_bar = 0;
    #1;
    chk("reset_abort", {29'b0, busy_o, peri_re_o, rd_valid_o}, 0);
    model_reset();
    @(negedge clk); @(negedge clk);
    reset_bar = 1;
    txn(0, 1, 'h250, 0, 0, 0, 0);
    txn(0, 1, 'h211, 0, 0, 0, 0);

    for (int i = 0; i < DEPTH; i++) txn(1, 0, i, 16'($urandom), 0, 0, 0);

    rnd_status = 1;
    for (int i = 0; i < 400; i++) begin
      int op, a, ch;
      op = $urandom_range(0, 11);
      ch = $urandom_range(0, NI - 1);
      peri_irq_i = 1'($urandom);
      wreg_i = 16'($urandom);
      case (op)
        0:  txn(1, 0, $urandom_range(0, DEPTH - 1), 16'($urandom), 0, 0, 0);
        1:  txn(0, 1, $urandom_range(0, DEPTH - 1), 0, 0, 0, 0);
        2:  txn(1, 0, 'h210 + 2 * ch, 16'($urandom), 0, 0, 0);
        3:  txn(0, 1, 'h210 + 2 * ch, 0, 0, 0, 0);
        4:  txn(1, 0, 'h211 + 2 * ch, 16'($urandom), 0, 0, 0);
        5:  txn(0, 1, 'h211 + 2 * ch, 0, 0, 0, 0);
        6:  begin
              txn(1, 0, 'h203, 16'($urandom), 0, 0, 0);
              chk("irq_gate", 32'(irq_o), 32'(peri_irq_i & m_irq_en));
            end
        7:  txn(0, 1, $urandom_range('h200, 'h203), 0, 0, 0, 0);
        8:  begin
              a = unm[$urandom_range(0, 5)];
              if ($urandom_range(0, 1) == 1) txn(1, 0, a, 16'($urandom), 0, 0, 0);
              else txn(0, 1, a, 0, 0, 0, 0);
            end
        9:  txn(0, 1, PBASE + $urandom_range(0, PSIZE - 1), 0, $urandom_range(1, 18), 16'($urandom), 0);
        10: txn(1, 0, PBASE + $urandom_range(0, PSIZE - 1), 16'($urandom), $urandom_range(1, 18), 0, 0);
        default: begin
              a = ($urandom_range(0, 1) == 1) ? 'h210 + 2 * ch : $urandom_range(0, DEPTH - 1);
              txn(1, 1, a, 16'($urandom), 0, 0, 0);
            end
      endcase
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(sbq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tip_memory_unit.md
Name: tip_memory_unit

Overview:
Parametrised second-generation data memory and Tightly Integrated Peripheral (TIP) unit for the 16-bit core. It provides word-addressed RAM, the status/TIP register block, and N independent indirect-access channels with optional post-increment. It also provides a peripheral window whose bus uses a ready handshake with a timeout, so the core can be stalled through busy. Everything runs on a single posedge clock; the write-on-negedge scheme is not used.

Parameters:
DATA_W, 16, data word width (minimum 16)
ADDR_W, 11, word address width
MEM_DEPTH, 512, RAM words at 0..MEM_DEPTH-1 (power of 2, at most 'h200)
N_IND, 2, indirect channels (1..8)
PERI_BASE, 'h300, first peripheral word address
PERI_SIZE, 'h100, peripheral window size in words
PERI_TIMEOUT, 15, maximum wait cycles for peri_ready

Ports:
clk  in  1  clock, all state on posedge
reset_bar  in  1  asynchronous active-low reset
addr  in  ADDR_W  word address, sampled when re or we is high and busy is low
wr_data  in  DATA_W  write data
we  in  1  write request
re  in  1  read request
rd_data  out  DATA_W  read result, valid while rd_valid is high
rd_valid  out  1  one-cycle pulse per completed read
busy  out  1  peripheral transaction in flight; core must stall
wreg  in  DATA_W  core W register (read-only mirror)
carry_in  in  1  ALU carry, captured every cycle
zero_in  in  1  ALU zero, captured every cycle
carry_out  out  1  stored carry
zero_out  out  1  stored zero
peri_addr  out  8  peripheral offset (addr - PERI_BASE)
peri_wdata  out  DATA_W  peripheral write data
peri_we  out  1  peripheral write strobe, held until ready
peri_re  out  1  peripheral read strobe, held until ready
peri_rdata  in  DATA_W  peripheral read data
peri_ready  in  1  peripheral completes transfer
peri_irq  in  1  peripheral interrupt request
irq  out  1  peri_irq AND irq_en (combinational)

Behaviour:
- Reset values:
  - rd_data=0, rd_valid=0, busy=0, carry_out=0, zero_out=0.
  - peri_we=0, peri_re=0, peri_addr=0, peri_wdata=0.
  - irq_en=0, to_err=0.
  - All pointers=0, all autoinc bits=0.
  - RAM contents are not reset.
- Request rules:
  - One request per cycle.
  - If we and re are both high, the write is performed and the read is ignored (no rd_valid).
  - Requests made while busy=1 are ignored.
- Address map:
  - RAM: 0..MEM_DEPTH-1.
  - 'h200 wreg (read-only).
  - 'h201 carry (bit0).
  - 'h202 zero (bit0).
  - 'h203 IRQ/ctrl: bit0 peri_irq (read-only), bit1 irq_en, bit2 to_err (sticky; write 1 to clear).
  - 'h210+2k: indirect value channel k.
  - 'h211+2k: indirect pointer channel k, fields [PW-1:0] pointer with PW=clog2(MEM_DEPTH), and [DATA_W-1] autoinc.
  - Peripheral window: PERI_BASE..PERI_BASE+PERI_SIZE-1.
  - Any other address is unmapped.
- Local reads (RAM, TIP registers, unmapped): rd_data and rd_valid appear 1 cycle after the request. Unmapped addresses return 'hDEAD, zero-extended to DATA_W.
- Local writes take effect at the request edge. Writes to wreg, bit0 of 'h203, and unmapped addresses are ignored.
- Status bits:
  - carry_out/zero_out load carry_in/zero_in every cycle.
  - A software write to 'h201/'h202 in the same cycle wins over the ALU input.
- Pointer writes: the written value is masked to MEM_DEPTH-1, so a pointer can only address RAM. Indirection cannot recurse.
- Indirect access: a read or write of value k accesses RAM[ptr_k]. If autoinc_k=1, ptr_k increments by 1 on that edge, wrapping from MEM_DEPTH-1 to 0. Channels are independent.
- Peripheral FSM, states IDLE, RD_WAIT, WR_WAIT:
  - IDLE -> RD_WAIT on re, or IDLE -> WR_WAIT on we, for an address in the window. On that edge: latch peri_addr and peri_wdata, assert peri_re or peri_we, set busy=1.
  - In a wait state, if peri_ready=1: drop the strobe and busy next edge, return to IDLE. On a read, rd_data=peri_rdata and rd_valid=1.
  - If PERI_TIMEOUT cycles elapse without ready: abort, set to_err=1, return to IDLE. A read returns 'hDEAD with rd_valid=1.
  - The wait counter resets on each entry to a wait state.
- Reset asserted mid-transaction aborts the transaction immediately: strobes and busy drop, no rd_valid.

Test Plan:
- Reset, write RAM[5]='h1234, read 5 -> rd_valid pulse 1 cycle later, rd_data='h1234. Read 'h1FF after reset -> no X on rd_data control path.
- Write ptr0='h8000|'h1FE, then 3 writes to value0 with 'hA,'hB,'hC -> RAM[1FE]=A, RAM[1FF]=B, RAM[0]=C. Read 'h211 -> 'h8001.
- Same cycle: carry_in=0 and software write 'h201='h3 -> carry_out=1. Next cycle with carry_in=0 -> carry_out=0.
- Read 'h305, peri_ready after 3 cycles with 'hBEEF -> peri_addr=5, busy high for 3 cycles, rd_data='hBEEF. A write request issued during busy is ignored.
- Peripheral write with peri_ready held low -> peri_we high for 15 cycles then dropped, to_err=1. Write 'h203='h4 clears to_err.
- Assert reset_bar low in RD_WAIT -> busy=0, peri_re=0 asynchronously, no rd_valid. Read 'h250 -> 'hDEAD.
